// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-bit signed multiply (radix-2 Booth) and signed divide
// (restoring, on magnitudes) sharing a single 65-bit accumulator. An operation
// takes 32 iterations plus one result cycle. Results are registered into
// Hi_out/Lo_out one cycle after DONE, together with the done pulse.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        MULT_on,
  input  logic        DIV_on,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic [31:0] Hi_out,
  output logic [31:0] Lo_out,
  output logic        busy,
  output logic        done,
  output logic        dzero
);

  typedef enum logic [2:0] {IDLE, MULT, DIV, DONE, DZ} state_t;

  state_t      state_q, state_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] m_q, m_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dzero_q, dzero_d;

  logic [32:0] booth_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Datapath arithmetic: Booth add/subtract on a 33-bit upper half so the
  // -2^31 * -2^31 case cannot overflow, plus restoring-division trial subtract.
  always_comb begin
    booth_sum = {acc_q[64], acc_q[64:33]};
    if (acc_q[1:0] == 2'b01) begin
      booth_sum = {acc_q[64], acc_q[64:33]} + {m_q[31], m_q};
    end else if (acc_q[1:0] == 2'b10) begin
      booth_sum = {acc_q[64], acc_q[64:33]} - {m_q[31], m_q};
    end
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, m_q};
    a_mag     = A_in[31] ? (~A_in + 32'd1) : A_in;
    b_mag     = B_in[31] ? (~B_in + 32'd1) : B_in;
    quo_fix   = q_neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix   = r_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  // Next-state and datapath update for the sequencer FSM.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dzero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MULT_on) begin
          acc_d    = {32'd0, B_in, 1'b0};
          m_d      = A_in;
          cnt_d    = 6'd0;
          is_div_d = 1'b0;
          state_d  = MULT;
        end else if (DIV_on) begin
          if (B_in == 32'd0) begin
            dzero_d = 1'b1;
            state_d = DZ;
          end else begin
            acc_d    = {33'd0, a_mag};
            m_d      = b_mag;
            cnt_d    = 6'd0;
            is_div_d = 1'b1;
            q_neg_d  = A_in[31] ^ B_in[31];
            r_neg_d  = A_in[31];
            state_d  = DIV;
          end
        end
      end
      MULT: begin
        acc_d = {booth_sum, acc_q[32:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
        end
      end
      DIV: begin
        if (!div_diff[32]) begin
          acc_d = {1'b0, div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {1'b0, div_shift[31:0], acc_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = acc_q[64:33];
          lo_d = acc_q[32:1];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      DZ: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= 65'd0;
      m_q      <= 32'd0;
      cnt_q    <= 6'd0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
      dzero_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dzero_q  <= dzero_d;
    end
  end

  assign busy   = (state_q == MULT) || (state_q == DIV);
  assign done   = done_q;
  assign dzero  = dzero_q;
  assign Hi_out = hi_q;
  assign Lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed tests for muldiv_sequencer with hand-computed
// results, latency, busy length, flag pulses, priority and reset abort.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        MULT_on;
  logic        DIV_on;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [31:0] Hi_out;
  logic [31:0] Lo_out;
  logic        busy;
  logic        done;
  logic        dzero;

  int n_compared;
  int n_mismatch;

  int          obs_done_at;
  int          obs_done_cnt;
  int          obs_dz_at;
  int          obs_dz_cnt;
  int          obs_busy_cnt;
  logic [31:0] obs_hi;
  logic [31:0] obs_lo;
  bit          obs_overlap;

  muldiv_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .MULT_on(MULT_on),
    .DIV_on (DIV_on),
    .A_in   (A_in),
    .B_in   (B_in),
    .Hi_out (Hi_out),
    .Lo_out (Lo_out),
    .busy   (busy),
    .done   (done),
    .dzero  (dzero)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a start request for one edge, then scramble the operand inputs
  // so that any failure to latch them shows up in the result.
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    MULT_on = m;
    DIV_on  = d;
    A_in    = a;
    B_in    = b;
    @(posedge clk);
    #1;
    MULT_on = 1'b0;
    DIV_on  = 1'b0;
    A_in    = 32'hDEAD_BEEF;
    B_in    = 32'h0BAD_F00D;
  endtask

  // Watch the outputs cycle by cycle after a start edge (k = cycles since it),
  // recording when done/dzero appear and how long busy stays high. At cycle
  // pulse_k a spurious start with different operands is driven for one cycle.
  task automatic observe(input int max_k, input bit stop_on_done, input int pulse_k);
    obs_done_at  = -1;
    obs_done_cnt = 0;
    obs_dz_at    = -1;
    obs_dz_cnt   = 0;
    obs_busy_cnt = 0;
    obs_hi       = 32'hxxxx_xxxx;
    obs_lo       = 32'hxxxx_xxxx;
    obs_overlap  = 1'b0;
    for (int k = 0; k <= max_k; k++) begin
      if (busy === 1'b1) obs_busy_cnt++;
      if (done === 1'b1 && dzero === 1'b1) obs_overlap = 1'b1;
      if (dzero === 1'b1) begin
        obs_dz_cnt++;
        if (obs_dz_at < 0) obs_dz_at = k;
      end
      if (done === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_at < 0) begin
          obs_done_at = k;
          obs_hi      = Hi_out;
          obs_lo      = Lo_out;
        end
        if (stop_on_done) break;
      end
      if (k == max_k) break;
      if (k == pulse_k) begin
        MULT_on = 1'b1;
        DIV_on  = 1'b1;
        A_in    = 32'd99;
        B_in    = 32'd0;
      end else if (k == pulse_k + 1) begin
        MULT_on = 1'b0;
        DIV_on  = 1'b0;
        A_in    = 32'hDEAD_BEEF;
        B_in    = 32'h0BAD_F00D;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reset asserted from time zero: all outputs low before any clock edge.
  task automatic test_reset();
    #3;
    n_compared++; if (Hi_out !== 32'd0) begin n_mismatch++; $display("[TB] FAIL reset_hi: got %h expected %h", Hi_out, 32'd0); end
    n_compared++; if (Lo_out !== 32'd0) begin n_mismatch++; $display("[TB] FAIL reset_lo: got %h expected %h", Lo_out, 32'd0); end
    n_compared++; if (busy !== 1'b0) begin n_mismatch++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_compared++; if (done !== 1'b0) begin n_mismatch++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_compared++; if (dzero !== 1'b0) begin n_mismatch++; $display("[TB] FAIL reset_dzero: got %b expected 0", dzero); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // 7 * -3 = -21, with latency and busy length checked.
  task automatic test_mult_basic();
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    observe(40, 1'b0, -10);
    n_compared++; if (obs_done_at !== 33) begin n_mismatch++; $display("[TB] FAIL mult_latency: got %0d expected 33", obs_done_at); end
    n_compared++; if (obs_busy_cnt !== 32) begin n_mismatch++; $display("[TB] FAIL mult_busy_len: got %0d expected 32", obs_busy_cnt); end
    n_compared++; if (obs_done_cnt !== 1) begin n_mismatch++; $display("[TB] FAIL mult_done_count: got %0d expected 1", obs_done_cnt); end
    n_compared++; if (obs_hi !== 32'hFFFF_FFFF) begin n_mismatch++; $display("[TB] FAIL mult_7x-3_hi: got %h expected %h", obs_hi, 32'hFFFF_FFFF); end
    n_compared++; if (obs_lo !== 32'hFFFF_FFEB) begin n_mismatch++; $display("[TB] FAIL mult_7x-3_lo: got %h expected %h", obs_lo, 32'hFFFF_FFEB); end
    n_compared++; if (Lo_out !== 32'hFFFF_FFEB) begin n_mismatch++; $display("[TB] FAIL mult_hold_lo: got %h expected %h", Lo_out, 32'hFFFF_FFEB); end
  endtask

  // Most-negative squared: (-2^31)^2 = 2^62.
  task automatic test_mult_min();
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    observe(40, 1'b0, -10);
    n_compared++; if (obs_hi !== 32'h4000_0000) begin n_mismatch++; $display("[TB] FAIL mult_min_hi: got %h expected %h", obs_hi, 32'h4000_0000); end
    n_compared++; if (obs_lo !== 32'h0000_0000) begin n_mismatch++; $display("[TB] FAIL mult_min_lo: got %h expected %h", obs_lo, 32'h0000_0000); end
  endtask

  // -7 / 2 = -3 rem -1, then the overflow case -2^31 / -1.
  task automatic test_div_signed();
    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    observe(40, 1'b0, -10);
    n_compared++; if (obs_done_at !== 33) begin n_mismatch++; $display("[TB] FAIL div_latency: got %0d expected 33", obs_done_at); end
    n_compared++; if (obs_busy_cnt !== 32) begin n_mismatch++; $display("[TB] FAIL div_busy_len: got %0d expected 32", obs_busy_cnt); end
    n_compared++; if (obs_lo !== 32'hFFFF_FFFD) begin n_mismatch++; $display("[TB] FAIL div_-7/2_quo: got %h expected %h", obs_lo, 32'hFFFF_FFFD); end
    n_compared++; if (obs_hi !== 32'hFFFF_FFFF) begin n_mismatch++; $display("[TB] FAIL div_-7/2_rem: got %h expected %h", obs_hi, 32'hFFFF_FFFF); end
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    observe(40, 1'b0, -10);
    n_compared++; if (obs_lo !== 32'h8000_0000) begin n_mismatch++; $display("[TB] FAIL div_ovf_quo: got %h expected %h", obs_lo, 32'h8000_0000); end
    n_compared++; if (obs_hi !== 32'h0000_0000) begin n_mismatch++; $display("[TB] FAIL div_ovf_rem: got %h expected %h", obs_hi, 32'h0000_0000); end
    n_compared++; if (obs_dz_cnt !== 0) begin n_mismatch++; $display("[TB] FAIL div_ovf_flag: got %0d expected 0", obs_dz_cnt); end
    start_op(1'b0, 1'b1, 32'd17, 32'hFFFF_FFFB);
    observe(40, 1'b0, -10);
    n_compared++; if (obs_lo !== 32'hFFFF_FFFD) begin n_mismatch++; $display("[TB] FAIL div_17/-5_quo: got %h expected %h", obs_lo, 32'hFFFF_FFFD); end
    n_compared++; if (obs_hi !== 32'd2) begin n_mismatch++; $display("[TB] FAIL div_17/-5_rem: got %h expected %h", obs_hi, 32'd2); end
  endtask

  // Divide by zero after a 5/2 result (Hi=1, Lo=2): dzero pulse, outputs held.
  task automatic test_div_zero();
    start_op(1'b0, 1'b1, 32'd5, 32'd2);
    observe(40, 1'b0, -10);
    n_compared++; if (obs_lo !== 32'd2 || obs_hi !== 32'd1) begin n_mismatch++; $display("[TB] FAIL div_5/2: got hi=%h lo=%h expected hi=1 lo=2", obs_hi, obs_lo); end
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    observe(10, 1'b0, -10);
    n_compared++; if (obs_dz_at !== 0) begin n_mismatch++; $display("[TB] FAIL dz_time: got %0d expected 0", obs_dz_at); end
    n_compared++; if (obs_dz_cnt !== 1) begin n_mismatch++; $display("[TB] FAIL dz_count: got %0d expected 1", obs_dz_cnt); end
    n_compared++; if (obs_done_cnt !== 0) begin n_mismatch++; $display("[TB] FAIL dz_done: got %0d expected 0", obs_done_cnt); end
    n_compared++; if (obs_busy_cnt !== 0) begin n_mismatch++; $display("[TB] FAIL dz_busy: got %0d expected 0", obs_busy_cnt); end
    n_compared++; if (Hi_out !== 32'd1) begin n_mismatch++; $display("[TB] FAIL dz_hold_hi: got %h expected %h", Hi_out, 32'd1); end
    n_compared++; if (Lo_out !== 32'd2) begin n_mismatch++; $display("[TB] FAIL dz_hold_lo: got %h expected %h", Lo_out, 32'd2); end
  endtask

  // Both starts together: multiply wins; a start pulse mid-run is ignored.
  task automatic test_priority();
    start_op(1'b1, 1'b1, 32'd6, 32'hFFFF_FFFF);
    observe(40, 1'b0, 5);
    n_compared++; if (obs_done_at !== 33) begin n_mismatch++; $display("[TB] FAIL prio_latency: got %0d expected 33", obs_done_at); end
    n_compared++; if (obs_done_cnt !== 1) begin n_mismatch++; $display("[TB] FAIL prio_done_count: got %0d expected 1", obs_done_cnt); end
    n_compared++; if (obs_dz_cnt !== 0) begin n_mismatch++; $display("[TB] FAIL prio_dzero: got %0d expected 0", obs_dz_cnt); end
    n_compared++; if (obs_hi !== 32'hFFFF_FFFF) begin n_mismatch++; $display("[TB] FAIL prio_hi: got %h expected %h", obs_hi, 32'hFFFF_FFFF); end
    n_compared++; if (obs_lo !== 32'hFFFF_FFFA) begin n_mismatch++; $display("[TB] FAIL prio_lo: got %h expected %h", obs_lo, 32'hFFFF_FFFA); end
  endtask

  // A start in the very cycle done is high is accepted.
  task automatic test_back_to_back();
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    observe(40, 1'b1, -10);
    n_compared++; if (obs_done_at !== 33) begin n_mismatch++; $display("[TB] FAIL b2b_first_latency: got %0d expected 33", obs_done_at); end
    n_compared++; if (obs_lo !== 32'd14 || obs_hi !== 32'd2) begin n_mismatch++; $display("[TB] FAIL b2b_first: got hi=%h lo=%h expected hi=2 lo=e", obs_hi, obs_lo); end
    start_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
    observe(40, 1'b0, -10);
    n_compared++; if (obs_done_at !== 33) begin n_mismatch++; $display("[TB] FAIL b2b_second_latency: got %0d expected 33", obs_done_at); end
    n_compared++; if (obs_hi !== 32'hFFFF_FFFF || obs_lo !== 32'hFFFF_FFFA) begin n_mismatch++; $display("[TB] FAIL b2b_second: got hi=%h lo=%h expected hi=ffffffff lo=fffffffa", obs_hi, obs_lo); end
  endtask

  // Reset mid-cycle at multiply iteration 10, then a clean 3 * 4.
  task automatic test_reset_abort();
    int done_seen;
    start_op(1'b1, 1'b0, 32'd5, 32'd5);
    observe(10, 1'b0, -10);
    #2;
    reset = 1'b0;
    #1;
    n_compared++; if (Hi_out !== 32'd0 || Lo_out !== 32'd0) begin n_mismatch++; $display("[TB] FAIL abort_outputs: got hi=%h lo=%h expected 0", Hi_out, Lo_out); end
    n_compared++; if (busy !== 1'b0) begin n_mismatch++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || dzero !== 1'b0) done_seen++;
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || dzero !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    n_compared++; if (done_seen !== 0) begin n_mismatch++; $display("[TB] FAIL abort_no_pulse: got %0d flagged cycles expected 0", done_seen); end
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    observe(40, 1'b0, -10);
    n_compared++; if (obs_done_at !== 33) begin n_mismatch++; $display("[TB] FAIL abort_next_latency: got %0d expected 33", obs_done_at); end
    n_compared++; if (obs_lo !== 32'd12 || obs_hi !== 32'd0) begin n_mismatch++; $display("[TB] FAIL abort_next_3x4: got hi=%h lo=%h expected hi=0 lo=c", obs_hi, obs_lo); end
  endtask

  // Test sequence.
  initial begin
    n_compared = 0;
    n_mismatch = 0;
    reset   = 1'b0;
    MULT_on = 1'b0;
    DIV_on  = 1'b0;
    A_in    = 32'd0;
    B_in    = 32'd0;
    test_reset();
    test_mult_basic();
    test_mult_min();
    test_div_signed();
    test_div_zero();
    test_priority();
    test_back_to_back();
    test_reset_abort();
    n_compared++; if (obs_overlap !== 1'b0) begin n_mismatch++; $display("[TB] FAIL flag_overlap: got %b expected 0", obs_overlap); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port MULT_on, input, 1 bit: start signed multiply; sampled on a rising edge while in IDLE.
REQ-004 SHALL have port DIV_on, input, 1 bit: start signed divide; sampled on a rising edge while in IDLE.
REQ-005 SHALL have port A_in, input, 32 bits: multiplicand / dividend, latched at start.
REQ-006 SHALL have port B_in, input, 32 bits: multiplier / divisor, latched at start.
REQ-007 SHALL have port Hi_out, output, 32 bits: product[63:32] or remainder.
REQ-008 SHALL have port Lo_out, output, 32 bits: product[31:0] or quotient.
REQ-009 SHALL have port busy, output, 1 bit: high while in the MULT or DIV state.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse; Hi_out/Lo_out are valid and updated.
REQ-011 SHALL have port dzero, output, 1 bit: one-cycle pulse on divide by zero.

Function
REQ-012 SHALL implement FSM states IDLE, MULT, DIV, DONE, DZ.
REQ-013 In IDLE with MULT_on=1, SHALL latch A_in/B_in, clear the iteration counter and go to MULT.
REQ-014 In IDLE with DIV_on=1 and MULT_on=0 and B_in!=0, SHALL latch operands and go to DIV.
REQ-015 In IDLE with DIV_on=1 and MULT_on=0 and B_in==0, SHALL go to DZ with no iterations.
REQ-016 If MULT_on and DIV_on are both high in the same cycle, SHALL give MULT priority and ignore DIV_on.
REQ-017 SHALL ignore MULT_on/DIV_on in every state other than IDLE; the latched operands are not disturbed.
REQ-018 MULT SHALL perform exactly 32 iterations, one per clock, using radix-2 Booth recoding on a 65-bit product register.
REQ-019 MULT SHALL produce the two's-complement signed 64-bit product of A and B.
REQ-020 DIV SHALL perform exactly 32 iterations, one per clock, as restoring division on the operand magnitudes.
REQ-021 DIV SHALL fix signs after iterating: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-022 DIV quotient SHALL truncate toward zero.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL give Lo=0x80000000, Hi=0x00000000, with no flag.
REQ-024 After the 32nd iteration, SHALL go to DONE, write Hi_out/Lo_out, and assert done for exactly one cycle, then return to IDLE.
REQ-025 Latency SHALL be fixed: start sampled at edge N gives done=1 during the cycle following edge N+33, with results visible at that time.
REQ-026 DZ SHALL assert dzero for exactly one cycle (the cycle after the start edge), keep Hi_out/Lo_out unchanged, keep done=0, then return to IDLE.
REQ-027 busy SHALL be 1 exactly in the MULT and DIV states; done and dzero SHALL never be high simultaneously.
REQ-028 Hi_out/Lo_out SHALL hold their last values until the next DONE state.
REQ-029 A new start SHALL be accepted in the first cycle IDLE is re-entered after DONE or DZ.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, Hi_out=0, Lo_out=0, busy=0, done=0, dzero=0, and counter=0, regardless of the clock.
REQ-031 Reset during MULT or DIV SHALL abort the operation with no done or dzero pulse; after release, the next start SHALL behave normally.

Verification
REQ-032 MULT A=7, B=0xFFFFFFFD -> done 33 cycles after start; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; busy high for 32 cycles.
REQ-033 MULT A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000.
REQ-034 DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; then DIV 0x80000000 by 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
REQ-035 DIV A=5, B=0 after a prior result of Hi=1, Lo=2 -> dzero pulse one cycle after start; done=0; Hi=1, Lo=2 retained.
REQ-036 MULT_on and DIV_on high together, then DIV_on pulsed at iteration 5 -> only a multiply runs; a single done at cycle 33.
REQ-037 reset driven low at MULT iteration 10, mid-cycle -> outputs zero at once and no done pulse; MULT 3x4 after release gives Lo=12, Hi=0.
